// File: rtl/rc_cmd_receiver.sv
// Remote-link command receiver: UART 8N1 byte FSM, 2-byte frame decoder,
// registered drive commands and a link-loss watchdog.
module rc_cmd_receiver #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600,
  parameter logic [7:0] HDR = 8'h55,
  parameter int TIMEOUT_MS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic cmd_up,
  output logic cmd_down,
  output logic cmd_left,
  output logic cmd_right,
  output logic frame_ok,
  output logic frame_err,
  output logic link_lost
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TCYC = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam logic [15:0] CPB_END = 16'(CPB - 1);
  localparam logic [15:0] HALF_END = 16'(HALF - 1);
  localparam logic [31:0] WD_END = 32'(TCYC - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bstate_t;

  typedef enum logic {
    F_HDR,
    F_CMD
  } fstate_t;

  logic rx_m, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  bstate_t bst, bst_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] sh, sh_n;
  logic brk, brk_n;
  logic byte_valid, bv_n;
  logic byte_fe, fe_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst <= B_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      brk <= 1'b0;
      byte_valid <= 1'b0;
      byte_fe <= 1'b0;
    end else begin
      bst <= bst_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      brk <= brk_n;
      byte_valid <= bv_n;
      byte_fe <= fe_n;
    end
  end

  always_comb begin
    bst_n = bst;
    cnt_n = cnt;
    bit_n = bit_cnt;
    sh_n = sh;
    brk_n = brk;
    bv_n = 1'b0;
    fe_n = 1'b0;
    unique case (bst)
      B_IDLE: begin
        if (!rx_s) begin
          bst_n = B_START;
          cnt_n = '0;
          bit_n = '0;
        end
      end
      B_START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          bst_n = rx_s ? B_IDLE : B_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      B_DATA: begin
        if (cnt == CPB_END) begin
          cnt_n = '0;
          sh_n = {rx_s, sh[7:1]};
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) bst_n = B_STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      B_STOP: begin
        // After a framing error, hold here until the line returns high
        if (brk) begin
          if (rx_s) begin
            brk_n = 1'b0;
            bst_n = B_IDLE;
          end
        end else if (cnt == CPB_END) begin
          cnt_n = '0;
          if (rx_s) begin
            bv_n = 1'b1;
            bst_n = B_IDLE;
          end else begin
            fe_n = 1'b1;
            brk_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: bst_n = B_IDLE;
    endcase
  end

  fstate_t fst, fst_n;
  logic ok_n, err_n;
  logic [3:0] cmd_q, cmd_n;
  logic [31:0] wd;
  logic chk_bad, conflict;

  assign chk_bad = sh[7:4] != ~sh[3:0];
  assign conflict = (sh[3] & sh[2]) | (sh[1] & sh[0]);

  always_comb begin
    fst_n = fst;
    ok_n = 1'b0;
    err_n = 1'b0;
    cmd_n = cmd_q;
    if (byte_fe) begin
      err_n = 1'b1;
      fst_n = F_HDR;
    end else if (byte_valid) begin
      unique case (fst)
        F_HDR: begin
          if (sh == HDR) fst_n = F_CMD;
        end
        F_CMD: begin
          if (sh != HDR) begin
            fst_n = F_HDR;
            unique case (1'b1)
              chk_bad: err_n = 1'b1;
              conflict: err_n = 1'b1;
              default: begin
                ok_n = 1'b1;
                cmd_n = sh[3:0];
              end
            endcase
          end
        end
        default: fst_n = F_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst <= F_HDR;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      cmd_q <= '0;
      wd <= '0;
      link_lost <= 1'b1;
    end else begin
      fst <= fst_n;
      frame_ok <= ok_n;
      frame_err <= err_n;
      if (ok_n) begin
        cmd_q <= cmd_n;
        wd <= '0;
        link_lost <= 1'b0;
      end else begin
        if (wd != '1) wd <= wd + 32'd1;
        if (wd >= WD_END) begin
          link_lost <= 1'b1;
          cmd_q <= '0;
        end
      end
    end
  end

  assign cmd_up = cmd_q[3];
  assign cmd_down = cmd_q[2];
  assign cmd_left = cmd_q[1];
  assign cmd_right = cmd_q[0];

endmodule
